redmule_core_obi_tcdm_adapter: RTL and testbench

Bridges the control core's OBI data port (req/gnt/rvalid) to a single HCI-style TCDM initiator port. It sits directly downstream of the core complex's `core_data_req_o` / `core_data_rsp_i` pair and upstream of the cluster TCDM interconnect. The block has three jobs:
- bound the number of outstanding transactions;
- keep responses in order;
- answer accesses outside the TCDM window locally with a bus error, without touching the interconnect.

---
 rtl/redmule_core_obi_tcdm_adapter.sv | 120 ++++++++++++
 tb/tb_redmule_core_obi_tcdm_adapter.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_core_obi_tcdm_adapter.sv
// OBI (req/gnt/rvalid) to HCI TCDM initiator bridge: bounds outstanding transactions, keeps
// responses in order, and answers accesses outside the TCDM window locally with a bus error.
module redmule_core_obi_tcdm_adapter #(
   parameter int unsigned          AddrWidth      = 32,
   parameter int unsigned          DataWidth      = 32,
   parameter int unsigned          MaxOutstanding = 2,
   parameter logic [AddrWidth-1:0] TcdmBase       = 32'h1000_0000,
   parameter logic [AddrWidth-1:0] TcdmSize       = 32'h0002_0000,
   parameter logic [DataWidth-1:0] ErrRdata       = 32'hBADC_AB1E
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   // OBI target side
   input  logic                   obi_req_i,
   output logic                   obi_gnt_o,
   input  logic [AddrWidth-1:0]   obi_addr_i,
   input  logic                   obi_we_i,
   input  logic [DataWidth/8-1:0] obi_be_i,
   input  logic [DataWidth-1:0]   obi_wdata_i,
   output logic                   obi_rvalid_o,
   output logic [DataWidth-1:0]   obi_rdata_o,
   output logic                   obi_err_o,
   // TCDM initiator side
   output logic                   tcdm_req_o,
   input  logic                   tcdm_gnt_i,
   output logic [AddrWidth-1:0]   tcdm_add_o,
   output logic                   tcdm_wen_o,
   output logic [DataWidth/8-1:0] tcdm_be_o,
   output logic [DataWidth-1:0]   tcdm_data_o,
   input  logic                   tcdm_r_valid_i,
   input  logic [DataWidth-1:0]   tcdm_r_data_i,
   output logic                   protocol_err_o
);

   localparam int unsigned          CntWidth = $clog2(MaxOutstanding + 1);
   localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxOutstanding);

   logic [AddrWidth-1:0] addr_off;
   logic                 in_range;
   logic                 cnt_zero;
   logic                 tcdm_fire;
   logic                 oor_gnt;
   logic                 rsp_ok;

   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic                 err_pend_q, err_pend_d;
   logic                 rvalid_q, rvalid_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 protocol_err_q, protocol_err_d;

   always_comb begin
      // Unsigned wrap makes addresses below the base fall out of range.
      addr_off  = obi_addr_i - TcdmBase;
      in_range  = (addr_off < TcdmSize);
      cnt_zero  = (cnt_q == '0);

      tcdm_req_o = obi_req_i & in_range & (cnt_q < CntMax) & ~err_pend_q;
      tcdm_fire  = tcdm_req_o & tcdm_gnt_i;
      // Out-of-range accesses wait for the TCDM pipe to drain so responses stay in order.
      oor_gnt    = obi_req_i & ~in_range & cnt_zero & ~err_pend_q;
      obi_gnt_o  = in_range ? tcdm_fire : oor_gnt;

      tcdm_add_o  = tcdm_req_o ? obi_addr_i  : '0;
      tcdm_wen_o  = tcdm_req_o ? ~obi_we_i   : 1'b0;
      tcdm_be_o   = tcdm_req_o ? obi_be_i    : '0;
      tcdm_data_o = tcdm_req_o ? obi_wdata_i : '0;

      rsp_ok = tcdm_r_valid_i & ~cnt_zero;

      cnt_d = cnt_q;
      case ({tcdm_fire, rsp_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // The error response is loaded at grant time so it appears one cycle later; err_pend
      // then blocks new grants during that response cycle.
      err_pend_d = oor_gnt;

      rvalid_d = 1'b0;
      rdata_d  = '0;
      err_d    = 1'b0;
      if (rsp_ok) begin
         rvalid_d = 1'b1;
         rdata_d  = tcdm_r_data_i;
      end else if (oor_gnt) begin
         rvalid_d = 1'b1;
         rdata_d  = ErrRdata;
         err_d    = 1'b1;
      end

      protocol_err_d = protocol_err_q | (tcdm_r_valid_i & cnt_zero);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q          <= '0;
         err_pend_q     <= 1'b0;
         rvalid_q       <= 1'b0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         err_pend_q     <= err_pend_d;
         rvalid_q       <= rvalid_d;
         rdata_q        <= rdata_d;
         err_q          <= err_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   assign obi_rvalid_o   = rvalid_q;
   assign obi_rdata_o    = rdata_q;
   assign obi_err_o      = err_q;
   assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_redmule_core_obi_tcdm_adapter.sv
// Self-checking bench for redmule_core_obi_tcdm_adapter: directed scenarios plus a randomized
// run against a queue-based model of outstanding TCDM transactions.
module tb_redmule_core_obi_tcdm_adapter;

   localparam int unsigned MAX  = 2;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] SIZE = 32'h0002_0000;
   localparam logic [31:0] ERRD = 32'hBADC_AB1E;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        obi_req_i = 1'b0;
   logic        obi_gnt_o;
   logic [31:0] obi_addr_i = '0;
   logic        obi_we_i = 1'b0;
   logic [3:0]  obi_be_i = '0;
   logic [31:0] obi_wdata_i = '0;
   logic        obi_rvalid_o;
   logic [31:0] obi_rdata_o;
   logic        obi_err_o;
   logic        tcdm_req_o;
   logic        tcdm_gnt_i = 1'b0;
   logic [31:0] tcdm_add_o;
   logic        tcdm_wen_o;
   logic [3:0]  tcdm_be_o;
   logic [31:0] tcdm_data_o;
   logic        tcdm_r_valid_i = 1'b0;
   logic [31:0] tcdm_r_data_i = '0;
   logic        protocol_err_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   redmule_core_obi_tcdm_adapter #(
      .AddrWidth      (32),
      .DataWidth      (32),
      .MaxOutstanding (MAX),
      .TcdmBase       (BASE),
      .TcdmSize       (SIZE),
      .ErrRdata       (ERRD)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .obi_req_i      (obi_req_i),
      .obi_gnt_o      (obi_gnt_o),
      .obi_addr_i     (obi_addr_i),
      .obi_we_i       (obi_we_i),
      .obi_be_i       (obi_be_i),
      .obi_wdata_i    (obi_wdata_i),
      .obi_rvalid_o   (obi_rvalid_o),
      .obi_rdata_o    (obi_rdata_o),
      .obi_err_o      (obi_err_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .protocol_err_o (protocol_err_o)
   );

   task automatic drive_idle();
      obi_req_i      = 1'b0;
      obi_addr_i     = '0;
      obi_we_i       = 1'b0;
      obi_be_i       = '0;
      obi_wdata_i    = '0;
      tcdm_gnt_i     = 1'b0;
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = '0;
   endtask

   task automatic set_req(input logic [31:0] a, input logic we);
      obi_req_i   = 1'b1;
      obi_addr_i  = a;
      obi_we_i    = we;
      obi_be_i    = 4'hF;
      obi_wdata_i = $urandom;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      drive_idle();
      #1;
      checks++;
      if ({obi_rvalid_o, obi_err_o, protocol_err_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got rvalid/err/perr=%b%b%b expected 000", obi_rvalid_o,
                  obi_err_o, protocol_err_o);
      end
      checks++;
      if (obi_rdata_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 00000000", obi_rdata_o);
      end
      checks++;
      if ({tcdm_req_o, obi_gnt_o} !== 2'b00 || tcdm_add_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_req: got req=%b gnt=%b add=%h expected 0 0 0", tcdm_req_o,
                  obi_gnt_o, tcdm_add_o);
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({obi_rvalid_o, obi_err_o, protocol_err_o, tcdm_req_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release: got %b%b%b%b expected 0000", obi_rvalid_o, obi_err_o,
                  protocol_err_o, tcdm_req_o);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      @(negedge clk_i);
      set_req(32'h1000_0010, 1'b0);
      tcdm_gnt_i = 1'b1;
      #1;
      checks++;
      if (tcdm_req_o !== 1'b1 || obi_gnt_o !== 1'b1) begin
         failures++;
         $display("FAIL single_req: got req=%b gnt=%b expected 1 1", tcdm_req_o, obi_gnt_o);
      end
      checks++;
      if (tcdm_add_o !== 32'h1000_0010 || tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF ||
          tcdm_data_o !== obi_wdata_i) begin
         failures++;
         $display("FAIL single_pass: got add=%h wen=%b be=%h expected 10000010 1 f", tcdm_add_o,
                  tcdm_wen_o, tcdm_be_o);
      end
      @(negedge clk_i);
      checks++;
      if (obi_rvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_early: got rvalid=%b expected 0", obi_rvalid_o);
      end
      drive_idle();
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = 32'hCAFE_F00D;
      @(negedge clk_i);
      tcdm_r_valid_i = 1'b0;
      checks++;
      if (obi_rvalid_o !== 1'b1 || obi_rdata_o !== 32'hCAFE_F00D || obi_err_o !== 1'b0) begin
         failures++;
         $display("FAIL single_rsp: got rvalid=%b rdata=%h err=%b expected 1 cafef00d 0",
                  obi_rvalid_o, obi_rdata_o, obi_err_o);
      end
      @(negedge clk_i);
      checks++;
      if (obi_rvalid_o !== 1'b0 || protocol_err_o !== 1'b0) begin
         failures++;
         $display("FAIL single_after: got rvalid=%b perr=%b expected 0 0", obi_rvalid_o,
                  protocol_err_o);
      end
   endtask

   // TCDM answers two cycles after each grant; four reads issued back to back.
   task automatic test_outstanding_limit();
      int gcyc[$];
      int rvcyc[$];
      int due[$];
      logic [31:0] dat[$];
      int issued = 0;
      int nresp  = 0;
      int exp_g[4] = '{0, 1, 3, 4};
      int exp_r[4] = '{3, 4, 6, 7};
      int got;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (obi_rvalid_o === 1'b1) begin
            rvcyc.push_back(c);
            checks++;
            if (obi_rdata_o !== 32'hD000_0000 + 32'(nresp) || obi_err_o !== 1'b0) begin
               failures++;
               $display("FAIL limit_order: got %h err=%b expected %h err=0", obi_rdata_o,
                        obi_err_o, 32'hD000_0000 + 32'(nresp));
            end
            nresp++;
         end
         drive_idle();
         if (issued < 4) set_req(BASE + 32'(issued * 4), 1'b0);
         tcdm_gnt_i = 1'b1;
         if (due.size() > 0 && due[0] == c) begin
            tcdm_r_valid_i = 1'b1;
            tcdm_r_data_i  = dat[0];
            void'(due.pop_front());
            void'(dat.pop_front());
         end
         #1;
         if (c == 2) begin
            checks++;
            if (tcdm_req_o !== 1'b0 || obi_gnt_o !== 1'b0) begin
               failures++;
               $display("FAIL limit_full: got req=%b gnt=%b expected 0 0", tcdm_req_o,
                        obi_gnt_o);
            end
         end
         if (obi_gnt_o === 1'b1) begin
            gcyc.push_back(c);
            due.push_back(c + 2);
            dat.push_back(32'hD000_0000 + 32'(issued));
            issued++;
         end
      end
      drive_idle();
      checks++;
      if (gcyc.size() != 4 || nresp != 4) begin
         failures++;
         $display("FAIL limit_count: got grants=%0d rsps=%0d expected 4 4", gcyc.size(), nresp);
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < gcyc.size()) ? gcyc[i] : -1;
         checks++;
         if (got != exp_g[i]) begin
            failures++;
            $display("FAIL limit_gnt_cycle%0d: got %0d expected %0d", i, got, exp_g[i]);
         end
         got = (i < rvcyc.size()) ? rvcyc[i] : -1;
         checks++;
         if (got != exp_r[i]) begin
            failures++;
            $display("FAIL limit_rsp_cycle%0d: got %0d expected %0d", i, got, exp_r[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      do_reset();
      @(negedge clk_i);
      set_req(32'h0000_0100, 1'b1);
      tcdm_gnt_i = 1'b1;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
         failures++;
         $display("FAIL oor_gnt: got gnt=%b req=%b expected 1 0", obi_gnt_o, tcdm_req_o);
      end
      @(negedge clk_i);
      checks++;
      if (obi_rvalid_o !== 1'b1 || obi_err_o !== 1'b1 || obi_rdata_o !== ERRD) begin
         failures++;
         $display("FAIL oor_rsp: got rvalid=%b err=%b rdata=%h expected 1 1 badcab1e",
                  obi_rvalid_o, obi_err_o, obi_rdata_o);
      end
      set_req(BASE - 32'h1, 1'b0);
      #1;
      checks++;
      if (obi_gnt_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
         failures++;
         $display("FAIL oor_busy: got gnt=%b req=%b expected 0 0", obi_gnt_o, tcdm_req_o);
      end
      @(negedge clk_i);
      checks++;
      if (obi_rvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL oor_single: got rvalid=%b expected 0", obi_rvalid_o);
      end
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
         failures++;
         $display("FAIL oor_gnt2: got gnt=%b req=%b expected 1 0", obi_gnt_o, tcdm_req_o);
      end
      @(negedge clk_i);
      drive_idle();
      checks++;
      if (obi_rvalid_o !== 1'b1 || obi_err_o !== 1'b1 || obi_rdata_o !== ERRD) begin
         failures++;
         $display("FAIL oor_rsp2: got rvalid=%b err=%b rdata=%h expected 1 1 badcab1e",
                  obi_rvalid_o, obi_err_o, obi_rdata_o);
      end
   endtask

   task automatic test_ordering();
      do_reset();
      @(negedge clk_i);
      set_req(BASE + 32'h40, 1'b0);
      tcdm_gnt_i = 1'b1;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1) begin
         failures++;
         $display("FAIL order_first: got gnt=%b expected 1", obi_gnt_o);
      end
      @(negedge clk_i);
      set_req(32'h2000_0000, 1'b0);
      #1;
      checks++;
      if (obi_gnt_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
         failures++;
         $display("FAIL order_wait: got gnt=%b req=%b expected 0 0", obi_gnt_o, tcdm_req_o);
      end
      @(negedge clk_i);
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = 32'h1357_9BDF;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b0) begin
         failures++;
         $display("FAIL order_wait_rsp: got gnt=%b expected 0", obi_gnt_o);
      end
      @(negedge clk_i);
      tcdm_r_valid_i = 1'b0;
      checks++;
      if (obi_rvalid_o !== 1'b1 || obi_rdata_o !== 32'h1357_9BDF || obi_err_o !== 1'b0) begin
         failures++;
         $display("FAIL order_tcdm_rsp: got rvalid=%b rdata=%h err=%b expected 1 13579bdf 0",
                  obi_rvalid_o, obi_rdata_o, obi_err_o);
      end
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1) begin
         failures++;
         $display("FAIL order_oor_gnt: got gnt=%b expected 1", obi_gnt_o);
      end
      @(negedge clk_i);
      drive_idle();
      checks++;
      if (obi_rvalid_o !== 1'b1 || obi_err_o !== 1'b1 || obi_rdata_o !== ERRD) begin
         failures++;
         $display("FAIL order_err_rsp: got rvalid=%b err=%b rdata=%h expected 1 1 badcab1e",
                  obi_rvalid_o, obi_err_o, obi_rdata_o);
      end
   endtask

   task automatic test_protocol_err();
      do_reset();
      @(negedge clk_i);
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = 32'h1234_5678;
      @(negedge clk_i);
      tcdm_r_valid_i = 1'b0;
      checks++;
      if (obi_rvalid_o !== 1'b0 || protocol_err_o !== 1'b1) begin
         failures++;
         $display("FAIL perr_set: got rvalid=%b perr=%b expected 0 1", obi_rvalid_o,
                  protocol_err_o);
      end
      set_req(BASE, 1'b0);
      tcdm_gnt_i = 1'b1;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1) begin
         failures++;
         $display("FAIL perr_cnt_clean: got gnt=%b expected 1", obi_gnt_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         drive_idle();
         checks++;
         if (protocol_err_o !== 1'b1) begin
            failures++;
            $display("FAIL perr_sticky%0d: got %b expected 1", i, protocol_err_o);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         set_req(BASE + 32'(i * 4), 1'b0);
         tcdm_gnt_i = 1'b1;
      end
      @(negedge clk_i);
      set_req(BASE + 32'h8, 1'b0);
      #1;
      checks++;
      if (tcdm_req_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_full: got req=%b expected 0", tcdm_req_o);
      end
      #2;
      rst_ni = 1'b0;
      drive_idle();
      #1;
      checks++;
      if ({obi_rvalid_o, obi_err_o, protocol_err_o, tcdm_req_o, obi_gnt_o} !== 5'b0 ||
          obi_rdata_o !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset: got %b%b%b%b%b rdata=%h expected 00000 0", obi_rvalid_o,
                  obi_err_o, protocol_err_o, tcdm_req_o, obi_gnt_o, obi_rdata_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      set_req(BASE + 32'hC, 1'b0);
      tcdm_gnt_i = 1'b1;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1 || tcdm_req_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_post_gnt: got gnt=%b req=%b expected 1 1", obi_gnt_o, tcdm_req_o);
      end
      @(negedge clk_i);
      drive_idle();
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = 32'h0BAD_F00D;
      @(negedge clk_i);
      checks++;
      if (obi_rvalid_o !== 1'b1 || obi_rdata_o !== 32'h0BAD_F00D || protocol_err_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_post_rsp: got rvalid=%b rdata=%h perr=%b expected 1 0badf00d 0",
                  obi_rvalid_o, obi_rdata_o, protocol_err_o);
      end
      // Stale response from before reset.
      @(negedge clk_i);
      tcdm_r_valid_i = 1'b0;
      checks++;
      if (obi_rvalid_o !== 1'b0 || protocol_err_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_late_rsp: got rvalid=%b perr=%b expected 0 1", obi_rvalid_o,
                  protocol_err_o);
      end
   endtask

   task automatic test_random();
      int          due_q[$];
      int          n = 3000;
      int          outst;
      logic        hold = 1'b0;
      logic        req, we, tg, rv, inr, e_treq, e_gnt, m_errp, oor;
      logic [31:0] addr, rd, wd;
      logic [3:0]  be;
      logic        e_rv, e_err;
      logic [31:0] e_rd;
      m_errp = 1'b0;
      e_rv   = 1'b0;
      e_err  = 1'b0;
      e_rd   = '0;
      req    = 1'b0;
      we     = 1'b0;
      addr   = '0;
      wd     = '0;
      be     = '0;
      do_reset();
      for (int c = 0; c < n; c++) begin
         @(negedge clk_i);
         checks++;
         if (obi_rvalid_o !== e_rv || obi_rdata_o !== e_rd || obi_err_o !== e_err) begin
            failures++;
            $display("FAIL rand_rsp c=%0d: got %b %h %b expected %b %h %b", c, obi_rvalid_o,
                     obi_rdata_o, obi_err_o, e_rv, e_rd, e_err);
         end
         if (!hold) begin
            req = (c < n - 20) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
               0:       addr = BASE;
               1:       addr = BASE + SIZE - 32'h1;
               2:       addr = BASE + SIZE;
               3:       addr = BASE - 32'h1;
               4:       addr = $urandom;
               default: addr = BASE + ($urandom % SIZE);
            endcase
            we = $urandom_range(0, 1);
            be = 4'($urandom);
            wd = $urandom;
         end
         tg = ($urandom_range(0, 9) < 7);
         rv = (due_q.size() > 0) && (due_q[0] <= c) && ($urandom_range(0, 4) != 0);
         rd = $urandom;
         obi_req_i      = req;
         obi_addr_i     = addr;
         obi_we_i       = we;
         obi_be_i       = be;
         obi_wdata_i    = wd;
         tcdm_gnt_i     = tg;
         tcdm_r_valid_i = rv;
         tcdm_r_data_i  = rd;

         outst  = due_q.size();
         inr    = ((addr - BASE) < SIZE);
         e_treq = req && inr && (outst < MAX) && !m_errp;
         e_gnt  = inr ? (e_treq && tg) : (req && outst == 0 && !m_errp);
         oor    = !inr && e_gnt;
         #1;
         checks++;
         if (tcdm_req_o !== e_treq || obi_gnt_o !== e_gnt) begin
            failures++;
            $display("FAIL rand_req c=%0d addr=%h: got req=%b gnt=%b expected %b %b", c, addr,
                     tcdm_req_o, obi_gnt_o, e_treq, e_gnt);
         end
         if (e_treq) begin
            checks++;
            if (tcdm_add_o !== addr || tcdm_wen_o !== !we || tcdm_be_o !== be ||
                tcdm_data_o !== wd) begin
               failures++;
               $display("FAIL rand_pass c=%0d: got %h %b %h %h expected %h %b %h %h", c,
                        tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o, addr, !we, be, wd);
            end
         end
         if (rv) void'(due_q.pop_front());
         if (e_treq && tg) due_q.push_back(c + $urandom_range(1, 3));
         e_rv   = rv || oor;
         e_rd   = rv ? rd : (oor ? ERRD : 32'h0);
         e_err  = !rv && oor;
         m_errp = oor;
         hold   = req && !e_gnt;
      end
      @(negedge clk_i);
      drive_idle();
      checks++;
      if (obi_rvalid_o !== e_rv || obi_rdata_o !== e_rd || obi_err_o !== e_err) begin
         failures++;
         $display("FAIL rand_last_rsp: got %b %h %b expected %b %h %b", obi_rvalid_o,
                  obi_rdata_o, obi_err_o, e_rv, e_rd, e_err);
      end
      checks++;
      if (protocol_err_o !== 1'b0) begin
         failures++;
         $display("FAIL rand_perr: got %b expected 0", protocol_err_o);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive_idle();
      test_reset();
      test_single_read();
      test_outstanding_limit();
      test_out_of_range();
      test_ordering();
      test_protocol_err();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
